// File: rtl/ecc_enc_arbiter.sv
// ecc_enc_arbiter: shares one fixed-latency ECC encoder between two requesters.
//   - Round-robin arbiter with credit protection (in-flight tags + FIFO occupancy).
//   - Registered issue stage (enc_valid/enc_data/enc_mod) to the encoder.
//   - Tag shift register aligned with the encoder latency, carrying {valid, id, err}.
//   - Result FIFO returning codewords in issue order with requester id and error flag.
// Ports:
//   clk, rst (async, active low)
//   reqN_valid/reqN_ready/reqN_data/reqN_mod : request ports (N = 0, 1)
//   enc_valid/enc_data/enc_mod                : registered issue to encoder
//   enc_result                                : encoder output, PIPE_LAT cycles after enc_valid
//   resp_valid/resp_ready/resp_data/resp_id/resp_err : result FIFO head
//   grant_cnt0/grant_cnt1                     : accept counters
// Optional feature macro: ECC_ARB_STATS_EN enables the saturating accept counters;
// when undefined the counters are absent and the outputs read zero.
module ecc_enc_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [1:0]            req0_mod,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [1:0]            req1_mod,
  output logic                  enc_valid,
  output logic [DATA_WIDTH-1:0] enc_data,
  output logic [1:0]            enc_mod,
  input  logic [DATA_WIDTH-1:0] enc_result,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_id,
  output logic                  resp_err,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned UseW = $clog2(FIFO_DEPTH + PIPE_LAT + 2) + 1;

  logic                  r_last_grant;
  logic                  r_enc_valid;
  logic [DATA_WIDTH-1:0] r_enc_data;
  logic [1:0]            r_enc_mod;
  logic                  r_enc_id;
  logic                  r_enc_err;
  logic [PIPE_LAT-1:0]   r_tag_v;
  logic [PIPE_LAT-1:0]   r_tag_id;
  logic [PIPE_LAT-1:0]   r_tag_err;
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_id;
  logic [FIFO_DEPTH-1:0] r_mem_err;
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [CntW-1:0]       r_count;

  logic [UseW-1:0]       w_used;
  logic                  w_credit;
  logic                  w_rdy0;
  logic                  w_rdy1;
  logic                  w_grant;
  logic                  w_gnt_id;
  logic                  w_wr;
  logic                  w_rd;

  // Occupied credits: issue register + tag pipe + FIFO. A request holds its credit
  // from grant until its FIFO entry is popped.
  always_comb begin
    w_used = UseW'(r_count) + UseW'(r_enc_valid);
    for (int i = 0; i < PIPE_LAT; i++) begin
      w_used = w_used + UseW'(r_tag_v[i]);
    end
  end

  assign w_credit = (w_used < UseW'(FIFO_DEPTH));

  // last_grant == 1 means req0 wins a tie; the two readies are mutually exclusive.
  assign w_rdy0   = w_credit & req0_valid & (~req1_valid | r_last_grant);
  assign w_rdy1   = w_credit & req1_valid & (~req0_valid | ~r_last_grant);
  assign w_grant  = w_rdy0 | w_rdy1;
  assign w_gnt_id = w_rdy1;

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;

  // Issue register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_enc_valid  <= 1'b0;
      r_enc_data   <= '0;
      r_enc_mod    <= 2'b00;
      r_enc_id     <= 1'b0;
      r_enc_err    <= 1'b0;
    end else begin
      r_enc_valid <= w_grant;
      if (w_grant) begin
        r_last_grant <= w_gnt_id;
        r_enc_data   <= w_gnt_id ? req1_data : req0_data;
        r_enc_mod    <= w_gnt_id ? req1_mod : req0_mod;
        r_enc_id     <= w_gnt_id;
        // Illegal mode is still issued so result ordering is preserved.
        r_enc_err    <= w_gnt_id ? (req1_mod == 2'b11) : (req0_mod == 2'b11);
      end
    end
  end

  assign enc_valid = r_enc_valid;
  assign enc_data  = r_enc_data;
  assign enc_mod   = r_enc_mod;

  // Tag pipe follows the issue register so its last stage lines up with enc_result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v   <= '0;
      r_tag_id  <= '0;
      r_tag_err <= '0;
    end else begin
      r_tag_v[0]   <= r_enc_valid;
      r_tag_id[0]  <= r_enc_id;
      r_tag_err[0] <= r_enc_err;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
        r_tag_err[i] <= r_tag_err[i-1];
      end
    end
  end

  assign w_wr = r_tag_v[PIPE_LAT-1];
  assign w_rd = resp_valid & resp_ready;

  // Result FIFO (registered, non-fall-through)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
      end
      r_mem_id  <= '0;
      r_mem_err <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_wr) begin
        r_mem_data[r_wptr] <= enc_result;
        r_mem_id[r_wptr]   <= r_tag_id[PIPE_LAT-1];
        r_mem_err[r_wptr]  <= r_tag_err[PIPE_LAT-1];
        r_wptr             <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign resp_valid = (r_count != '0);
  assign resp_data  = r_mem_data[r_rptr];
  assign resp_id    = r_mem_id[r_rptr];
  assign resp_err   = r_mem_err[r_rptr];

`ifndef SYNTHESIS
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_wr && (r_count == CntW'(FIFO_DEPTH))));
`endif

`ifdef ECC_ARB_STATS_EN
  logic [15:0] r_gcnt0;
  logic [15:0] r_gcnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gcnt0 <= 16'd0;
      r_gcnt1 <= 16'd0;
    end else begin
      if (w_rdy0 && (r_gcnt0 != 16'hFFFF)) r_gcnt0 <= r_gcnt0 + 16'd1;
      if (w_rdy1 && (r_gcnt1 != 16'hFFFF)) r_gcnt1 <= r_gcnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_gcnt0;
  assign grant_cnt1 = r_gcnt1;
`else
  assign grant_cnt0 = 16'd0;
  assign grant_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_ecc_enc_arbiter.sv
// Bench for ecc_enc_arbiter: directed stimulus, a stub encoder pipeline, an accept
// logger that pushes expected responses, and a monitor that pops and compares.
module tb_ecc_enc_arbiter;
  localparam int DW = 32;
  localparam int PL = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic [DW-1:0] req1_data = '0;
  logic [1:0]    req0_mod = 2'b00;
  logic [1:0]    req1_mod = 2'b00;
  logic          req0_ready, req1_ready;
  logic          enc_valid;
  logic [DW-1:0] enc_data;
  logic [1:0]    enc_mod;
  logic [DW-1:0] enc_result;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          resp_id, resp_err;
  logic [15:0]   grant_cnt0, grant_cnt1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          id;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   grant_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_err_seen = 0;

  always #5 clk = ~clk;

  ecc_enc_arbiter #(.DATA_WIDTH(DW), .PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_mod   (req0_mod),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_mod   (req1_mod),
    .enc_valid  (enc_valid),
    .enc_data   (enc_data),
    .enc_mod    (enc_mod),
    .enc_result (enc_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // Stub encoder: codeword = ~data for legal modes, zero for mode 11.
  function automatic logic [DW-1:0] code_of(input logic [DW-1:0] d, input logic [1:0] m);
    return (m == 2'b11) ? '0 : ~d;
  endfunction

  logic [DW-1:0] enc_pipe [PL];
  always @(posedge clk) begin
    enc_pipe[0] <= code_of(enc_data, enc_mod);
    for (int i = 1; i < PL; i++) enc_pipe[i] <= enc_pipe[i-1];
  end
  assign enc_result = enc_pipe[PL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Accept logger: handshakes seen at negedge take effect at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (req0_valid && req1_valid) check1("ready_exclusive", req0_ready & req1_ready, 1'b0);
      if (req0_valid && req0_ready) begin
        grant_q.push_back(0);
        sb_q.push_back({code_of(req0_data, req0_mod), 1'b0, req0_mod == 2'b11});
      end
      if (req1_valid && req1_ready) begin
        grant_q.push_back(1);
        sb_q.push_back({code_of(req1_data, req1_mod), 1'b1, req1_mod == 2'b11});
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0d data %h, required no response",
                 resp_id, resp_data);
      end else begin
        e = sb_q.pop_front();
        check("resp_data", resp_data, e.d);
        check1("resp_id", resp_id, e.id);
        check1("resp_err", resp_err, e.err);
        if (resp_err) n_err_seen++;
      end
    end
  end

  task automatic wait_grants(input int n, input int bound);
    int k;
    k = 0;
    while (grant_q.size() < n && k < bound) begin
      @(posedge clk);
      k++;
    end
    check("grant_count", grant_q.size(), n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit port, input logic [DW-1:0] d, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (port) begin req1_valid = 1'b1; req1_data = d; req1_mod = m; end
    else begin req0_valid = 1'b1; req0_data = d; req0_mod = m; end
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = port ? req1_ready : req0_ready;
      if (!ok) begin @(posedge clk); #1; end
    end
    check1("issue_handshake", ok, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    int            stale;
    bit            exp_alt [8];
    logic [15:0]   exp_cnt;
    exp_alt = '{0, 1, 0, 1, 0, 1, 0, 1};
`ifdef ECC_ARB_STATS_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = 16'd0;
`endif

    // Reset values
    #12;
    check1("rst_enc_valid", enc_valid, 1'b0);
    check("rst_enc_data", enc_data, 32'h0);
    check("rst_enc_mod", {30'b0, enc_mod}, 32'h0);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check1("rst_resp_id", resp_id, 1'b0);
    check1("rst_resp_err", resp_err, 1'b0);
    check("rst_grant_cnt0", {16'b0, grant_cnt0}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Both requesters continuously valid: alternate starting with req0
    grant_q.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 32'h1111_0000; req0_mod = 2'b00;
    req1_valid = 1'b1; req1_data = 32'h2222_0000; req1_mod = 2'b01;
    wait_grants(8, 60);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) check("alt_order", grant_q[i], 32'(exp_alt[i]));
    @(negedge clk);
    check("alt_cnt0", {16'b0, grant_cnt0}, {16'b0, exp_cnt});
    check("alt_cnt1", {16'b0, grant_cnt1}, {16'b0, exp_cnt});
    drain();

    // Single req0: latency
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 32'h0000_00A5; req0_mod = 2'b00;
    @(negedge clk); check1("single_ready", req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check1("single_enc_valid_t1", enc_valid, 1'b1);
    check("single_enc_data", enc_data, 32'h0000_00A5);
    @(negedge clk); check1("single_enc_valid_t2", enc_valid, 1'b0);
    @(negedge clk); check1("single_resp_valid_t3", resp_valid, 1'b0);
    @(negedge clk);
    check1("single_resp_valid_t4", resp_valid, 1'b1);
    check("single_resp_data", resp_data, 32'hFFFF_FF5A);
    check1("single_resp_id", resp_id, 1'b0);
    drain();

    // Backpressure: credit limits accepts to FIFO depth
    resp_ready = 1'b0;
    grant_q.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_mod = 2'b10;
    for (int i = 0; i < 12; i++) begin
      req0_data = 32'h3000_0000 + i;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check1("bp_ready_low", req0_ready, 1'b0);
    check("bp_accepts", grant_q.size(), FD);
    held = resp_data;
    @(negedge clk);
    check1("bp_head_valid", resp_valid, 1'b1);
    check("bp_head_stable", resp_data, held);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk); check1("bp_ready_pop_cycle", req0_ready, 1'b0);
    @(posedge clk); #1 req0_data = 32'h3000_00F0;
    @(negedge clk); check1("bp_ready_after_pop", req0_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 req0_data = 32'h3000_0100 + i;
    end
    req0_valid = 1'b0;
    drain();

    // Illegal mode on req1 between legal neighbours
    n_err_seen = 0;
    issue(1'b0, 32'h0000_0055, 2'b01);
    issue(1'b1, 32'hABCD_0066, 2'b11);
    issue(1'b0, 32'h0000_0077, 2'b10);
    drain();
    check("illegal_err_count", n_err_seen, 1);

    // Reset with two results in the FIFO and two in flight
    resp_ready = 1'b0;
    grant_q.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 32'h4444_0000; req0_mod = 2'b00;
    wait_grants(4, 20);
    #1 req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check1("mid_pre_resp_valid", resp_valid, 1'b1);
    rst = 1'b0;
    #1;
    check1("mid_enc_valid", enc_valid, 1'b0);
    check1("mid_resp_valid", resp_valid, 1'b0);
    check("mid_resp_data", resp_data, 32'h0);
    check1("mid_resp_id", resp_id, 1'b0);
    check("mid_grant_cnt0", {16'b0, grant_cnt0}, 32'h0);
    sb_q.delete();
    grant_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    resp_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) stale++;
    end
    check("mid_stale_resp", stale, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 32'h5555_0000; req0_mod = 2'b00;
    req1_valid = 1'b1; req1_data = 32'h6666_0000; req1_mod = 2'b00;
    @(negedge clk);
    check1("tie_req0_ready", req0_ready, 1'b1);
    check1("tie_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk); check1("tie_req1_next", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0;
    drain();

    // Streaming with resp_ready high: FIFO wraps several times
    grant_q.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_mod = 2'b01;
    for (int k = 0; k < 60 && grant_q.size() < 12; k++) begin
      req0_data = 32'h7000_0000 + k;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    check("wrap_accepts", grant_q.size(), 12);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
